// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Sequences the multi-cycle core through FETCH/DECODE/EXEC/MEM/WB for each
//   instruction class. It also runs the data-memory req/ack handshake with a
//   timeout, applies fetch stalls, resolves the flag-dependent conditional
//   branch, halts on an illegal opcode, and counts retired instructions.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   opcode         instruction word, latched when ir_en=1
//   stall          holds the FSM in FETCH while high
//   alu_zero       ALU zero flag, used by CJ in EXEC
//   mem_ack        single-cycle data-memory completion pulse
//   ir_en, pc_en, pc_src, alu_op, alu_src_const   datapath controls
//   mem_req, mem_we                               data-memory request
//   rf_we, rf_wd_mem, rf_dst_r2                   register-file controls
//   illegal, timeout                              sticky error flags
//   halted                                        FSM parked in HALT
//   instr_count                                   retired count, wraps
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | first cycle after reset, always moves on to FETCH
// FETCH  | wait for !stall, then latch the opcode
// DECODE | classify; J completes here, illegal opcodes go to HALT
// EXEC   | ALU cycle; CJ completes here
// MEM    | hold mem_req until mem_ack, or time out
// WB     | register-file write and PC increment
// HALT   | absorbing; only reset leaves
module multicycle_controller #(
  parameter int OPCODE_W    = 6,
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int COUNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                stall,
  input  logic                alu_zero,
  input  logic                mem_ack,
  output logic                ir_en,
  output logic                pc_en,
  output logic [1:0]          pc_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src_const,
  output logic                mem_req,
  output logic                mem_we,
  output logic                rf_we,
  output logic                rf_wd_mem,
  output logic                rf_dst_r2,
  output logic                illegal,
  output logic                timeout,
  output logic                halted,
  output logic [COUNT_W-1:0]  instr_count
);

  // The wait counter never has to hold MEM_TIMEOUT itself: the FSM leaves MEM
  // in the cycle where the count would step onto it.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

  localparam logic [1:0] PC_PLUS1  = 2'b00;
  localparam logic [1:0] PC_OFFSET = 2'b01;
  localparam logic [1:0] PC_CONST  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t              state, state_nxt;
  logic [OPCODE_W-1:0] opcode_q;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                set_illegal, set_timeout;

  logic [3:0] op;
  logic       is_r, is_i, is_mem, is_stm, is_ldm, is_cj, is_j, is_legal;

  assign op     = opcode_q[OPCODE_W-1 -: 4];
  assign is_r   = (op[3:2] == 2'b00);
  assign is_i   = (op[3:2] == 2'b01);
  assign is_mem = (op[3:1] == 3'b100);
  assign is_stm = is_mem && (opcode_q[2:1] == 2'b00);
  assign is_ldm = is_mem && (opcode_q[2:1] == 2'b01);
  assign is_cj  = (op[3:1] == 3'b101);
  assign is_j   = (op == 4'b1100);
  assign is_legal = is_r | is_i | is_stm | is_ldm | is_cj | is_j;

  always_comb begin
    state_nxt     = state;
    set_illegal   = 1'b0;
    set_timeout   = 1'b0;
    ir_en         = 1'b0;
    pc_en         = 1'b0;
    pc_src        = PC_PLUS1;
    alu_op        = '0;
    alu_src_const = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    rf_we         = 1'b0;
    rf_wd_mem     = 1'b0;
    rf_dst_r2     = 1'b0;
    halted        = 1'b0;

    case (state)
      S_IDLE: state_nxt = S_FETCH;

      S_FETCH: begin
        ir_en = !stall;
        if (!stall) state_nxt = S_DECODE;
      end

      S_DECODE: begin
        if (is_j) begin
          pc_en     = 1'b1;
          pc_src    = PC_CONST;
          state_nxt = S_FETCH;
        end else if (!is_legal) begin
          set_illegal = 1'b1;
          state_nxt   = S_HALT;
        end else begin
          state_nxt = S_EXEC;
        end
      end

      S_EXEC: begin
        if (is_r || is_i) alu_op = opcode_q[ALU_OP_W-1:0];
        alu_src_const = is_i | is_mem;
        if (is_cj) begin
          // opcode_q[2] selects BNZ, which inverts the sense of the zero flag
          pc_en     = 1'b1;
          pc_src    = (alu_zero ^ opcode_q[2]) ? PC_OFFSET : PC_PLUS1;
          state_nxt = S_FETCH;
        end else if (is_mem) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end

      S_MEM: begin
        mem_req       = 1'b1;
        alu_src_const = 1'b1;
        mem_we        = is_stm;
        if (mem_ack) begin
          if (is_stm) begin
            pc_en     = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end else if (TIMEOUT_EN && (wait_cnt == WAIT_LAST)) begin
          set_timeout = 1'b1;
          state_nxt   = S_HALT;
        end
      end

      S_WB: begin
        rf_we = 1'b1;
        pc_en = 1'b1;
        if (is_ldm) begin
          rf_wd_mem = 1'b1;
          rf_dst_r2 = 1'b1;
        end else begin
          alu_op        = opcode_q[ALU_OP_W-1:0];
          alu_src_const = is_i;
        end
        state_nxt = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      opcode_q    <= '0;
      wait_cnt    <= '0;
      instr_count <= '0;
      illegal     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ir_en) opcode_q <= opcode;
      // Staying in MEM means no ack arrived this cycle; any exit clears.
      if (state == S_MEM && state_nxt == S_MEM) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                                      wait_cnt <= '0;
      if (pc_en)       instr_count <= instr_count + COUNT_W'(1);
      if (set_illegal) illegal <= 1'b1;
      if (set_timeout) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  localparam int TMO = 16;

  logic       clk, rst_n;
  logic [5:0] opcode;
  logic       stall, alu_zero, mem_ack;

  logic        ir_en, pc_en, alu_src_const, mem_req, mem_we;
  logic        rf_we, rf_wd_mem, rf_dst_r2, illegal, timeout, halted;
  logic [1:0]  pc_src;
  logic [2:0]  alu_op;
  logic [15:0] instr_count;

  // Second instance with a 4-bit counter so wrap-around is reachable quickly.
  logic        w_ir_en, w_pc_en, w_alu_src_const, w_mem_req, w_mem_we;
  logic        w_rf_we, w_rf_wd_mem, w_rf_dst_r2, w_illegal, w_timeout, w_halted;
  logic [1:0]  w_pc_src;
  logic [2:0]  w_alu_op;
  logic [3:0]  w_instr_count;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .stall(stall),
    .alu_zero(alu_zero), .mem_ack(mem_ack),
    .ir_en(ir_en), .pc_en(pc_en), .pc_src(pc_src), .alu_op(alu_op),
    .alu_src_const(alu_src_const), .mem_req(mem_req), .mem_we(mem_we),
    .rf_we(rf_we), .rf_wd_mem(rf_wd_mem), .rf_dst_r2(rf_dst_r2),
    .illegal(illegal), .timeout(timeout), .halted(halted),
    .instr_count(instr_count)
  );

  multicycle_controller #(.COUNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .stall(stall),
    .alu_zero(alu_zero), .mem_ack(mem_ack),
    .ir_en(w_ir_en), .pc_en(w_pc_en), .pc_src(w_pc_src), .alu_op(w_alu_op),
    .alu_src_const(w_alu_src_const), .mem_req(w_mem_req), .mem_we(w_mem_we),
    .rf_we(w_rf_we), .rf_wd_mem(w_rf_wd_mem), .rf_dst_r2(w_rf_dst_r2),
    .illegal(w_illegal), .timeout(w_timeout), .halted(w_halted),
    .instr_count(w_instr_count)
  );

  logic [31:0] all_outs;
  logic [15:0] w_outs;
  assign all_outs = {ir_en, pc_en, pc_src, alu_op, alu_src_const, mem_req, mem_we,
                     rf_we, rf_wd_mem, rf_dst_r2, illegal, timeout, halted, instr_count};
  assign w_outs   = {w_ir_en, w_pc_en, w_pc_src, w_alu_op, w_alu_src_const, w_mem_req,
                     w_mem_we, w_rf_we, w_rf_wd_mem, w_rf_dst_r2, w_illegal, w_timeout,
                     w_halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 retire, 1 illegal halt, 2 timeout halt
  typedef struct {
    int kind;
    int lat;
    int pc_src;
    int rf_we;
    int wd_mem;
    int dst_r2;
    int alu_op;
    int src_const;
    int mem_cycles;
    int mem_we;
    int count_before;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   model_count = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference behaviour per instruction, from the class table and latencies.
  function automatic exp_t model_of(input logic [5:0] o, input int w, input bit az,
                                    input int cnt);
    exp_t e;
    e = '{default: 0};
    e.count_before = cnt;
    casez (o)
      6'b00????: begin e.lat = 4; e.rf_we = 1; e.alu_op = int'(o[2:0]); end
      6'b01????: begin e.lat = 4; e.rf_we = 1; e.alu_op = int'(o[2:0]); e.src_const = 1; end
      6'b10000?: begin
        e.mem_we = 1;
        if (w <= TMO) begin e.lat = 3 + w; e.src_const = 1; e.mem_cycles = w; end
        else begin e.kind = 2; e.lat = 4 + TMO; e.mem_cycles = TMO; end
      end
      6'b10001?: begin
        if (w <= TMO) begin
          e.lat = 4 + w; e.rf_we = 1; e.wd_mem = 1; e.dst_r2 = 1; e.mem_cycles = w;
        end else begin e.kind = 2; e.lat = 4 + TMO; e.mem_cycles = TMO; end
      end
      6'b1010??: begin e.lat = 3; e.pc_src = az ? 1 : 0; end
      6'b1011??: begin e.lat = 3; e.pc_src = az ? 0 : 1; end
      6'b1100??: begin e.lat = 2; e.pc_src = 2; end
      default:   begin e.kind = 1; e.lat = 3; end
    endcase
    return e;
  endfunction

  // Monitor: pops an expectation whenever the DUT retires or halts.
  initial begin
    int   cyc, start, memc, mwe, prev_h, act_kind;
    exp_t e;
    cyc = 0; start = 0; memc = 0; mwe = 0; prev_h = 0;
    forever begin
      @(negedge clk); #2;
      cyc++;
      if (!rst_n) begin
        prev_h = 0; memc = 0; mwe = 0;
      end else begin
        chk("w4_lockstep", int'(w_outs), int'(all_outs[31:16]));
        if (ir_en) begin start = cyc; memc = 0; mwe = 0; end
        if (mem_req) begin memc++; if (mem_we) mwe = 1; end
        if (pc_en) begin
          if (sb.size() == 0) chk("retire_unexpected", 1, 0);
          else begin
            e = sb.pop_front();
            act_kind = 0;
            chk("event_kind", act_kind, e.kind);
            chk("latency", cyc - start + 1, e.lat);
            chk("pc_src", int'(pc_src), e.pc_src);
            chk("rf_we", int'(rf_we), e.rf_we);
            chk("rf_wd_mem", int'(rf_wd_mem), e.wd_mem);
            chk("rf_dst_r2", int'(rf_dst_r2), e.dst_r2);
            chk("alu_op", int'(alu_op), e.alu_op);
            chk("alu_src_const", int'(alu_src_const), e.src_const);
            chk("mem_cycles", memc, e.mem_cycles);
            chk("mem_we", mwe, e.mem_we);
            chk("instr_count", int'(instr_count), e.count_before);
            chk("instr_count_w4", int'(w_instr_count), e.count_before % 16);
          end
        end
        if (halted && !prev_h) begin
          if (sb.size() == 0) chk("halt_unexpected", 1, 0);
          else begin
            e = sb.pop_front();
            act_kind = illegal ? 1 : (timeout ? 2 : 3);
            chk("halt_kind", act_kind, e.kind);
            chk("halt_latency", cyc - start + 1, e.lat);
            chk("halt_mem_cycles", memc, e.mem_cycles);
            chk("halt_illegal", int'(illegal), (e.kind == 1) ? 1 : 0);
            chk("halt_timeout", int'(timeout), (e.kind == 2) ? 1 : 0);
          end
        end
        if (halted) chk("halt_quiet", int'({ir_en, pc_en, rf_we, mem_req}), 0);
        prev_h = halted ? 1 : 0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; stall = 1'b0; mem_ack = 1'b0;
    #1;
    chk("reset_outputs", int'(all_outs), 0);
    sb.delete();
    model_count = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Call with the DUT about to spend the next cycle in FETCH.
  task automatic run_instr(input logic [5:0] o, input int stalls, input int w,
                           input bit az, input int abort_at);
    exp_t e;
    int   cnt;
    bit   done;
    @(negedge clk);
    opcode = o; alu_zero = az; mem_ack = 1'b0;
    for (int s = 0; s < stalls; s++) begin
      stall = 1'b1;
      mem_ack = 1'($urandom_range(0, 1));
      #1;
      chk("stall_ir_en", int'(ir_en), 0);
      @(negedge clk);
    end
    stall = 1'b0; mem_ack = 1'b0;
    #1;
    chk("fetch_ir_en", int'(ir_en), 1);
    e = model_of(o, w, az, model_count);
    if (e.kind == 0) model_count = (model_count + 1) % 65536;
    sb.push_back(e);
    cnt = 0; done = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      opcode = 6'($urandom);
      #1;
      if (abort_at > 0 && mem_req && cnt + 1 == abort_at) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'(all_outs), 0);
        sb.delete();
        model_count = 0;
        @(negedge clk);
        rst_n = 1'b1;
        done = 1'b1;
      end else if (pc_en || halted) begin
        done = 1'b1;
      end else if (mem_req) begin
        cnt++;
        mem_ack = (cnt == w);
        if (mem_ack) begin
          #1;
          if (pc_en) done = 1'b1;
        end
      end else begin
        mem_ack = ($urandom_range(0, 3) == 0);
      end
    end
    if (!done) chk("instr_completes", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    exp_t       t;
    logic [5:0] o;
    rst_n = 1'b0; opcode = '0; stall = 1'b0; alu_zero = 1'b0; mem_ack = 1'b0;
    do_reset();

    run_instr(6'b000101, 0, 1, 1'b0, 0);   // R
    run_instr(6'b100010, 0, 3, 1'b0, 0);   // LDM, ack on 3rd MEM cycle
    run_instr(6'b101000, 0, 1, 1'b1, 0);   // BZ taken
    run_instr(6'b101000, 1, 1, 1'b0, 0);   // BZ not taken
    run_instr(6'b101100, 0, 1, 1'b0, 0);   // BNZ taken
    run_instr(6'b110000, 4, 1, 1'b0, 0);   // J after 4 stall cycles
    run_instr(6'b010011, 2, 1, 1'b1, 0);   // I
    run_instr(6'b100000, 0, 1, 1'b0, 0);   // STM, immediate ack
    run_instr(6'b100011, 0, TMO, 1'b0, 0); // LDM, ack on the last allowed cycle

    for (int n = 0; n < 40; n++) begin
      do begin
        o = 6'($urandom_range(0, 63));
        t = model_of(o, 1, 1'b0, 0);
      end while (t.kind != 0);
      run_instr(o, $urandom_range(0, 2), $urandom_range(1, 5), 1'($urandom_range(0, 1)), 0);
    end

    run_instr(6'b100000, 0, 100, 1'b0, 0); // STM, no ack -> timeout halt
    repeat (4) begin
      @(negedge clk);
      mem_ack = ~mem_ack;
      stall = 1'($urandom_range(0, 1));
    end
    #1;
    chk("timeout_sticky", int'(timeout), 1);
    chk("halted_held", int'(halted), 1);
    do_reset();

    run_instr(6'b100010, 0, 10, 1'b0, 2);  // LDM aborted by reset mid-MEM
    run_instr(6'b001110, 0, 1, 1'b0, 0);   // R after abort, count restarts
    run_instr(6'b111111, 0, 1, 1'b0, 0);   // illegal -> halt
    repeat (3) @(negedge clk);
    #1;
    chk("illegal_sticky", int'(illegal), 1);
    chk("illegal_halted", int'(halted), 1);
    do_reset();

    repeat (2) @(negedge clk);
    #3;
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Parametrised multi-cycle successor to the single-cycle opcode decoder. An FSM sequences FETCH/DECODE/EXEC/MEM/WB per instruction class.
- Adds a data-memory req/ack handshake with timeout, fetch stall, a flag-dependent conditional branch, sticky illegal-opcode halt and a retired-instruction counter.
- Sits between the instruction register/datapath and the data memory of the multi-cycle core.

Parameters:
- OPCODE_W, 6, opcode width; class fields are the top 4 bits, ALU function is the low bits.
- ALU_OP_W, 3, ALU function width, taken from latched opcode[ALU_OP_W-1:0].
- MEM_TIMEOUT, 16, max cycles waiting for mem_ack; 0 disables the timeout.
- COUNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OPCODE_W  opcode from instruction memory; sampled when ir_en=1.
- stall  in  1  hold in FETCH while high.
- alu_zero  in  1  ALU zero flag, valid in EXEC.
- mem_ack  in  1  data-memory completion, single-cycle pulse.
- ir_en  out  1  load instruction register.
- pc_en  out  1  update PC.
- pc_src  out  2  00 plus1, 01 offset, 10 const.
- alu_op  out  ALU_OP_W  ALU function.
- alu_src_const  out  1  ALU B operand = immediate.
- mem_req  out  1  data-memory request.
- mem_we  out  1  write qualifier for mem_req.
- rf_we  out  1  register-file write enable.
- rf_wd_mem  out  1  write data from memory (0 = ALU).
- rf_dst_r2  out  1  destination field = r2.
- illegal  out  1  sticky illegal-opcode flag.
- timeout  out  1  sticky memory-timeout flag.
- halted  out  1  FSM is in HALT.
- instr_count  out  COUNT_W  retired instructions, wraps.

Behaviour:
- Class decode uses op = opcode_q[OPCODE_W-1 -: 4]:
  - R: op[3:2]=00.
  - I: op[3:2]=01.
  - MEM: op[3:1]=100; function opcode_q[2:1]: 00=STM, 01=LDM, other=illegal.
  - CJ: op[3:1]=101; opcode_q[2]=0 is BZ, 1 is BNZ.
  - J: op=1100.
  - All other encodings are illegal.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset (async, rst_n=0):
  - State IDLE; opcode_q, wait counter, instr_count, illegal and timeout all cleared.
  - All outputs 0, including pc_src=00 and alu_op=0.
  - IDLE always moves to FETCH on the next clock.
- Outputs are decoded from state and opcode_q. Only EXEC pc_src for CJ also depends on alu_zero. Every output not named for a state is 0.
- FETCH:
  - ir_en = !stall.
  - If stall, stay in FETCH; otherwise latch opcode and go to DECODE.
- DECODE:
  - J: pc_en=1, pc_src=10, retire, then FETCH. Total 2 cycles.
  - Illegal: set illegal, go to HALT.
  - Otherwise go to EXEC.
- EXEC:
  - alu_op driven for R and I.
  - alu_src_const=1 for I and MEM.
  - CJ: pc_en=1; pc_src=01 if (alu_zero XOR opcode_q[2]), else 00; retire, then FETCH. Total 3 cycles.
  - MEM classes go to MEM; R and I go to WB.
- MEM:
  - mem_req=1 and alu_src_const=1 held every cycle until mem_ack; mem_we=1 for STM.
  - On the ack cycle: STM asserts pc_en=1, pc_src=00, retires and goes to FETCH; LDM goes to WB.
  - The wait counter increments each MEM cycle without ack and clears on leaving MEM.
  - If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with no ack: set timeout, go to HALT.
  - mem_ack outside MEM is ignored.
- WB:
  - rf_we=1, pc_en=1, pc_src=00, retire, then FETCH.
  - R/I: alu_op held and rf_wd_mem=0; I also holds alu_src_const=1.
  - LDM: rf_wd_mem=1, rf_dst_r2=1.
- Per-class latency:
  - R/I = 4 cycles.
  - STM = 4 cycles + wait cycles.
  - LDM = 5 cycles + wait cycles.
- Retire: instr_count += 1 in the pc_en cycle, modulo 2^COUNT_W.
- HALT: absorbing state; halted=1, all enables 0; only reset exits.
- stall is honoured in FETCH only; it is ignored in all other states.
- Reset mid-instruction aborts immediately. No partial pc_en or rf_we pulse may follow reset release.

Test Plan:
- Reset, then R opcode 6'b000101 with stall=0: IDLE, FETCH, DECODE, EXEC, then WB with rf_we=1, pc_en=1, alu_op=3'b101; instr_count=1 after 5 cycles.
- LDM opcode 6'b100010, mem_ack on the 3rd MEM cycle: mem_req high for exactly 3 cycles with mem_we=0; WB has rf_wd_mem=1, rf_dst_r2=1; total 7 cycles.
- CJ BZ 6'b101000 with alu_zero=1: pc_src=01, pc_en=1 in EXEC. Repeat with alu_zero=0: pc_src=00. BNZ 6'b101100 with alu_zero=0: pc_src=01.
- J 6'b110000 with stall=1 for 4 cycles in FETCH: ir_en=0 while stalled, then DECODE gives pc_en=1, pc_src=10.
- STM 6'b100000 with no ack, MEM_TIMEOUT=16: after 16 MEM cycles timeout=1 and halted=1, held until rst_n=0. Illegal 6'b111111: illegal=1 from the cycle after DECODE.
- instr_count at 16'hFFFF retiring a J wraps to 0. rst_n pulsed low mid-MEM: all outputs 0 immediately and asynchronously.
